cache_ctrl: RTL and testbench

Memory-access controller between the CPU data port and the small fully-associative LRU cache. Per request: look up the cache; serve hits directly; fetch misses from backing memory over a req/ack handshake and fill the cache. Writes are write-through and write-allocate. Keeps saturating hit/miss counters for debug.

---
 rtl/cache_ctrl.sv | 138 +++++++++++++
 tb/tb_cache_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// Controller between the CPU data port, a small fully-associative cache and backing memory.
// Reads hit in the cache or miss to memory; writes go through to memory and allocate in the cache.
module cache_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_busy,
  output logic                  cpu_ready,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic                  cache_we,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  input  logic                  cache_hit,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, DONE} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] a_addr, a_addr_next;
  logic                  a_we, a_we_next;
  logic [DATA_WIDTH-1:0] a_data, a_data_next;
  logic                  a_miss, a_miss_next;
  logic                  mem_req_next, mem_we_next;
  logic [DATA_WIDTH-1:0] cpu_rdata_next;
  logic [CNT_WIDTH-1:0]  hit_cnt_next, miss_cnt_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      a_addr    <= '0;
      a_we      <= 1'b0;
      a_data    <= '0;
      a_miss    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      cpu_rdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      state     <= state_next;
      a_addr    <= a_addr_next;
      a_we      <= a_we_next;
      a_data    <= a_data_next;
      a_miss    <= a_miss_next;
      mem_req   <= mem_req_next;
      mem_we    <= mem_we_next;
      cpu_rdata <= cpu_rdata_next;
      hit_cnt   <= hit_cnt_next;
      miss_cnt  <= miss_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    a_addr_next    = a_addr;
    a_we_next      = a_we;
    a_data_next    = a_data;
    a_miss_next    = a_miss;
    mem_req_next   = mem_req;
    mem_we_next    = mem_we;
    cpu_rdata_next = cpu_rdata;
    hit_cnt_next   = hit_cnt;
    miss_cnt_next  = miss_cnt;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          a_addr_next = cpu_addr;
          a_we_next   = cpu_we;
          a_data_next = cpu_wdata;
          a_miss_next = 1'b0;
          state_next  = LOOKUP;
        end
      end
      LOOKUP: begin
        if (a_we) begin
          mem_req_next = 1'b1;
          mem_we_next  = 1'b1;
          state_next   = MEM_WR;
        end else if (cache_hit) begin
          // Read data is loaded into cpu_rdata now so it is valid during the ready pulse.
          a_data_next    = cache_rdata;
          cpu_rdata_next = cache_rdata;
          if (hit_cnt != '1) hit_cnt_next = hit_cnt + CNT_WIDTH'(1);
          state_next     = DONE;
        end else begin
          a_miss_next  = 1'b1;
          if (miss_cnt != '1) miss_cnt_next = miss_cnt + CNT_WIDTH'(1);
          mem_req_next = 1'b1;
          mem_we_next  = 1'b0;
          state_next   = MEM_RD;
        end
      end
      MEM_RD: begin
        if (mem_ack) begin
          a_data_next    = mem_rdata;
          cpu_rdata_next = mem_rdata;
          mem_req_next   = 1'b0;
          state_next     = DONE;
        end
      end
      MEM_WR: begin
        if (mem_ack) begin
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
          state_next   = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Fills on misses and writes; the DONE write also refreshes LRU recency.
  assign cpu_busy    = (state != IDLE);
  assign cpu_ready   = (state == DONE);
  assign cache_we    = (state == DONE) && (a_we || a_miss);
  assign cache_addr  = a_addr;
  assign cache_wdata = a_data;
  assign mem_addr    = a_addr;
  assign mem_wdata   = a_data;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: reset, read miss, read hit, write-through, busy/abort, counter saturation.
// Counters are built 2 bits wide so the saturation case is reachable in a few transactions.
module tb_cache_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       cpu_busy, cpu_ready;
  logic [7:0] cpu_rdata;
  logic [7:0] cache_addr, cache_wdata, cache_rdata;
  logic       cache_we, cache_hit;
  logic       mem_req, mem_we, mem_ack;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0] hit_cnt, miss_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .cache_addr(cache_addr), .cache_we(cache_we), .cache_wdata(cache_wdata),
    .cache_rdata(cache_rdata), .cache_hit(cache_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    // Reset held with random inputs: every output stays zero.
    for (int i = 0; i < 3; i++) begin
      cpu_req = 1'($urandom); cpu_we = 1'($urandom);
      cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom);
      cache_rdata = 8'($urandom); cache_hit = 1'($urandom);
      mem_rdata = 8'($urandom); mem_ack = 1'($urandom);
      smp();
      check("rst_busy", cpu_busy, 0);
      check("rst_ready", cpu_ready, 0);
      check("rst_rdata", cpu_rdata, 0);
      check("rst_cache", {cache_addr, cache_we, cache_wdata}, 0);
      check("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
      check("rst_cnt", {hit_cnt, miss_cnt}, 0);
      cyc();
    end
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    cache_rdata = 0; cache_hit = 0; mem_rdata = 0; mem_ack = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      check("idle_memreq", mem_req, 0);
      check("idle_cachewe", cache_we, 0);
      check("idle_busy", cpu_busy, 0);
      cyc();
    end

    // Read miss to 0x12, memory acks in cycle 4 with 0x5A.
    $display("txn read miss addr=12 data=5a");
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h12;
    smp(); check("miss_c0_busy", cpu_busy, 0); cyc();
    cpu_req = 0;
    smp(); check("miss_c1_busy", cpu_busy, 1); check("miss_c1_memreq", mem_req, 0); cyc();
    for (int c = 2; c <= 3; c++) begin
      smp();
      check("miss_memreq", mem_req, 1);
      check("miss_memwe", mem_we, 0);
      check("miss_memaddr", mem_addr, 8'h12);
      check("miss_early_ready", cpu_ready, 0);
      cyc();
    end
    mem_ack = 1; mem_rdata = 8'h5A;
    smp(); check("miss_c4_memreq", mem_req, 1); cyc();
    mem_ack = 0; mem_rdata = 8'h00;
    smp();
    check("miss_ready", cpu_ready, 1);
    check("miss_rdata", cpu_rdata, 8'h5A);
    check("miss_cachewe", cache_we, 1);
    check("miss_cacheaddr", cache_addr, 8'h12);
    check("miss_cachewdata", cache_wdata, 8'h5A);
    check("miss_c5_memreq", mem_req, 0);
    check("miss_misscnt", miss_cnt, 1);
    check("miss_hitcnt", hit_cnt, 0);
    cyc();
    smp();
    check("miss_c6_ready", cpu_ready, 0);
    check("miss_c6_cachewe", cache_we, 0);
    check("miss_c6_busy", cpu_busy, 0);
    check("miss_c6_rdata_hold", cpu_rdata, 8'h5A);
    cyc(); cyc();

    // Read hit to 0x12: ready in cycle 2, no memory traffic.
    $display("txn read hit addr=12 data=5a");
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h12; cache_hit = 1; cache_rdata = 8'h5A;
    cyc();
    cpu_req = 0;
    smp(); check("hit_c1_memreq", mem_req, 0); check("hit_c1_ready", cpu_ready, 0); cyc();
    smp();
    check("hit_ready", cpu_ready, 1);
    check("hit_rdata", cpu_rdata, 8'h5A);
    check("hit_memreq", mem_req, 0);
    check("hit_cachewe", cache_we, 0);
    check("hit_hitcnt", hit_cnt, 1);
    check("hit_misscnt", miss_cnt, 1);
    cyc();
    cache_hit = 0; cache_rdata = 0;
    smp(); check("hit_c3_ready", cpu_ready, 0); cyc();

    // Write 0xC3 to 0x34, ack in cycle 3; a stale cache_hit must be ignored.
    $display("txn write addr=34 data=c3");
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h34; cpu_wdata = 8'hC3;
    cyc();
    cpu_req = 0; cpu_we = 0; cpu_wdata = 0; cache_hit = 1; cache_rdata = 8'hEE;
    cyc();
    cache_hit = 0; cache_rdata = 0;
    smp();
    check("wr_c2_memreq", mem_req, 1);
    check("wr_c2_memwe", mem_we, 1);
    check("wr_c2_memwdata", mem_wdata, 8'hC3);
    check("wr_c2_memaddr", mem_addr, 8'h34);
    cyc();
    mem_ack = 1;
    smp(); check("wr_c3_memreq", mem_req, 1); check("wr_c3_memwe", mem_we, 1); cyc();
    mem_ack = 0;
    smp();
    check("wr_ready", cpu_ready, 1);
    check("wr_cachewe", cache_we, 1);
    check("wr_cachewdata", cache_wdata, 8'hC3);
    check("wr_cacheaddr", cache_addr, 8'h34);
    check("wr_rdata_unchanged", cpu_rdata, 8'h5A);
    check("wr_memreq_off", {mem_req, mem_we}, 0);
    check("wr_counters", {hit_cnt, miss_cnt}, {2'd1, 2'd1});
    cyc(); cyc();

    // Read back 0x34 from the cache.
    $display("txn read hit addr=34 data=c3");
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h34; cache_hit = 1; cache_rdata = 8'hC3;
    cyc();
    cpu_req = 0;
    cyc();
    smp();
    check("rb_ready", cpu_ready, 1);
    check("rb_rdata", cpu_rdata, 8'hC3);
    check("rb_hitcnt", hit_cnt, 2);
    cyc();
    cache_hit = 0; cache_rdata = 0;
    cyc();

    // Busy request ignored, then reset mid-MEM_RD and a late ack.
    $display("txn read miss addr=56 aborted by reset");
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h56;
    cyc();
    cpu_req = 0;
    cyc();
    smp(); check("ab_c2_memreq", mem_req, 1); cyc();
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h55; cpu_wdata = 8'h99;
    cyc();
    cpu_req = 0; cpu_we = 0; cpu_wdata = 0;
    smp();
    check("ab_busy_ignored_addr", mem_addr, 8'h56);
    check("ab_busy_ignored_we", mem_we, 0);
    check("ab_busy_ignored_req", mem_req, 1);
    #2 rst = 1'b0;
    #1;
    check("ab_async_memreq", mem_req, 0);
    check("ab_async_busy", cpu_busy, 0);
    check("ab_async_cnt", {hit_cnt, miss_cnt}, 0);
    cyc();
    rst = 1'b1; mem_ack = 1; mem_rdata = 8'h77;
    cyc();
    mem_ack = 0; mem_rdata = 0;
    smp();
    check("ab_late_ready", cpu_ready, 0);
    check("ab_late_busy", cpu_busy, 0);
    check("ab_late_cachewe", cache_we, 0);
    check("ab_late_rdata", cpu_rdata, 0);
    cyc();

    // Five read misses to distinct addresses: miss counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      logic [7:0] a, d;
      a = 8'h80 + 8'(i);
      d = 8'hA0 + 8'(i);
      $display("txn read miss addr=%0h data=%0h", a, d);
      cpu_req = 1; cpu_we = 0; cpu_addr = a;
      cyc();
      cpu_req = 0;
      cyc();
      smp(); check("sat_memreq", mem_req, 1); check("sat_memaddr", mem_addr, a); cyc();
      mem_ack = 1; mem_rdata = d;
      cyc();
      mem_ack = 0; mem_rdata = 0;
      smp();
      check("sat_ready", cpu_ready, 1);
      check("sat_rdata", cpu_rdata, d);
      check("sat_misscnt", miss_cnt, (i + 1 > 3) ? 3 : i + 1);
      check("sat_hitcnt", hit_cnt, 0);
      cyc();
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
